// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operand width,
// funct3 encodings of the M extension and the unit's FSM state encoding.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bus of the multiply/divide unit.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the source holds valid and its payload stable until that edge,
// and ready may not depend combinationally on the same side's valid.
interface mul_div_unit_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               in_op;
  logic [4:0]               in_rd;
  logic [rv_pkg::XLEN-1:0]  in_rs1_data;
  logic [rv_pkg::XLEN-1:0]  in_rs2_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [4:0]               out_rd;
  logic [rv_pkg::XLEN-1:0]  out_data;
  logic                     busy;
  logic [4:0]               busy_rd;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_rd, out_data, busy, busy_rd
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_rd, out_data, busy, busy_rd
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_bit_o
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;

  // Trial value needs one extra bit; once it is >= divisor the difference
  // is below the divisor, so the low word of the subtraction is exact.
  always_comb begin
    trial     = {rem_i, dividend_bit_i};
    diff      = trial[XLEN-1:0] - divisor_i;
    quo_bit_o = (trial >= {1'b0, divisor_i});
    rem_o     = quo_bit_o ? diff : trial[XLEN-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on
// accept, a primer cycle loads the accumulator, 32 radix-2 steps run, and a
// fix-up cycle applies the sign and picks the result word.
module mul_div_unit
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mul_div_unit_if.slave bus,
  output mdu_state_e    dbg_state
);

  localparam int            CW       = 6;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN);

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              a_signed, b_signed, a_neg, b_neg, is_div, special;
  logic [XLEN-1:0]   a_in, b_in, a_mag, b_mag, special_res;
  logic [XLEN-1:0]   step_rem;
  logic              step_qbit;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_word, div_fix, fix_res;

  // Operand conditioning: signedness per op, magnitudes, early-out cases
  always_comb begin
    a_in     = bus.in_rs1_data;
    b_in     = bus.in_rs2_data;
    is_div   = bus.in_op[2];
    a_signed = (bus.in_op == F3_MULH) || (bus.in_op == F3_MULHSU) ||
               (bus.in_op == F3_DIV)  || (bus.in_op == F3_REM);
    b_signed = (bus.in_op == F3_MULH) || (bus.in_op == F3_DIV) ||
               (bus.in_op == F3_REM);
    a_neg    = a_signed && a_in[XLEN-1];
    b_neg    = b_signed && b_in[XLEN-1];
    a_mag    = a_neg ? (~a_in + 1'b1) : a_in;
    b_mag    = b_neg ? (~b_in + 1'b1) : b_in;
    special  = EARLY_OUT && is_div &&
               ((b_in == '0) ||
                (!bus.in_op[0] && (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == '1)));
    if (b_in == '0) special_res = bus.in_op[1] ? a_in : '1;
    else            special_res = bus.in_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  mdu_div_step u_div_step (
    .rem_i          (acc_q[2*XLEN-1:XLEN]),
    .dividend_bit_i (acc_q[XLEN-1]),
    .divisor_i      (b_q),
    .rem_o          (step_rem),
    .quo_bit_o      (step_qbit)
  );

  // Datapath helpers: shift-add partial sum and sign fix-up of the result
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    div_word = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix  = neg_q ? (~div_word + 1'b1) : div_word;
    if (op_q[2])              fix_res = div_fix;
    else if (op_q == F3_MUL)  fix_res = prod_fix[XLEN-1:0];
    else                      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // FSM next state and register updates; flush overrides everything
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    a_d        = a_q;
    b_d        = b_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_rd_d   = out_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && !flush) begin
          op_d  = bus.in_op;
          rd_d  = bus.in_rd;
          a_d   = a_mag;
          b_d   = b_mag;
          cnt_d = '0;
          // Quotient of x/0 must stay all-ones, so a zero divisor never negates it
          if (is_div) neg_d = bus.in_op[1] ? a_neg : ((a_neg ^ b_neg) && (b_in != '0));
          else        neg_d = a_neg ^ b_neg;
          if (special) begin
            out_data_d = special_res;
            out_rd_d   = bus.in_rd;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          acc_d = {{XLEN{1'b0}}, a_q};
        end else begin
          if (op_q[2]) acc_d = {step_rem, acc_q[XLEN-2:0], step_qbit};
          else         acc_d = {mul_sum, acc_q[XLEN-1:1]};
          if (cnt_q == LAST_CNT) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        out_data_d = fix_res;
        out_rd_d   = rd_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_rd_q   <= out_rd_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !flush;
  assign bus.out_valid = (state_q == ST_DONE) && !flush;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.busy_rd   = (state_q != ST_IDLE) ? rd_q : 5'd0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: two instances (EARLY_OUT=1 and EARLY_OUT=0) share
// one stimulus stream and are checked every cycle against an arithmetic model.
module tb_mul_div_unit;
  import rv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared drive ----------------
  logic        drv_valid = 1'b0;
  logic [2:0]  drv_op = 3'd0;
  logic [4:0]  drv_rd = 5'd0;
  logic [31:0] drv_a = 32'd0;
  logic [31:0] drv_b = 32'd0;
  logic        drv_ready = 1'b1;

  mul_div_unit_if bus0 ();
  mul_div_unit_if bus1 ();
  mdu_state_e dbg0, dbg1;

  assign bus0.in_valid = drv_valid;    assign bus1.in_valid = drv_valid;
  assign bus0.in_op = drv_op;          assign bus1.in_op = drv_op;
  assign bus0.in_rd = drv_rd;          assign bus1.in_rd = drv_rd;
  assign bus0.in_rs1_data = drv_a;     assign bus1.in_rs1_data = drv_a;
  assign bus0.in_rs2_data = drv_b;     assign bus1.in_rs2_data = drv_b;
  assign bus0.out_ready = drv_ready;   assign bus1.out_ready = drv_ready;

  mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .dbg_state(dbg0));
  mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_it (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .dbg_state(dbg1));

  logic [1:0]  rdy_w, val_w, busy_w;
  logic [4:0]  ord_w [2];
  logic [4:0]  brd_w [2];
  logic [31:0] odat_w [2];
  assign rdy_w  = {bus1.in_ready, bus0.in_ready};
  assign val_w  = {bus1.out_valid, bus0.out_valid};
  assign busy_w = {bus1.busy, bus0.busy};
  assign ord_w[0] = bus0.out_rd;     assign ord_w[1] = bus1.out_rd;
  assign brd_w[0] = bus0.busy_rd;    assign brd_w[1] = bus1.busy_rd;
  assign odat_w[0] = bus0.out_data;  assign odat_w[1] = bus1.out_data;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic string nm(string s, int i);
    return $sformatf("%s_%s", (i == 0) ? "eo" : "it", s);
  endfunction

  // Architectural result of an RV32M op
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && ((b == 0) ||
           (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_busy [2];
  int          m_left [2];
  logic [4:0]  m_rd [2];
  logic [31:0] m_data [2];
  int          acc_cnt [2];
  int          acc_cyc [2];
  bit          m_rst_seen = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    m_rst_seen = rst;
    for (int i = 0; i < 2; i++) begin
      if (rst || flush) begin
        m_busy[i] = 1'b0;
        m_left[i] = 0;
      end else if (!m_busy[i]) begin
        if (drv_valid) begin
          m_busy[i] = 1'b1;
          m_rd[i]   = drv_rd;
          m_data[i] = ref_result(drv_op, drv_a, drv_b);
          m_left[i] = (i == 0 && is_special(drv_op, drv_a, drv_b)) ? 0 : 34;
          acc_cnt[i]++;
          acc_cyc[i] = cyc;
        end
      end else if (m_left[i] > 0) begin
        m_left[i]--;
      end else if (drv_ready) begin
        m_busy[i] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          check_en = 1'b0;
  logic        exp_v;
  int          lat [2];
  int          lat_for [2] = '{0, 0};
  logic [31:0] hs_data [2];
  int          hs_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        if (rst && m_rst_seen) begin
          chk(nm("rst_out_valid", i), 64'(val_w[i]), 64'd0);
          chk(nm("rst_busy", i), 64'(busy_w[i]), 64'd0);
          chk(nm("rst_busy_rd", i), 64'(brd_w[i]), 64'd0);
          chk(nm("rst_out_data", i), 64'(odat_w[i]), 64'd0);
          chk(nm("rst_out_rd", i), 64'(ord_w[i]), 64'd0);
        end else begin
          exp_v = m_busy[i] && (m_left[i] == 0) && !flush;
          chk(nm("in_ready", i), 64'(rdy_w[i]), 64'(!m_busy[i] && !flush));
          chk(nm("out_valid", i), 64'(val_w[i]), 64'(exp_v));
          chk(nm("busy", i), 64'(busy_w[i]), 64'(m_busy[i]));
          chk(nm("busy_rd", i), 64'(brd_w[i]), 64'(m_busy[i] ? m_rd[i] : 5'd0));
          if (exp_v) begin
            chk(nm("out_data", i), 64'(odat_w[i]), 64'(m_data[i]));
            chk(nm("out_rd", i), 64'(ord_w[i]), 64'(m_rd[i]));
          end
          if (val_w[i] && (lat_for[i] != acc_cnt[i])) begin
            lat_for[i] = acc_cnt[i];
            lat[i]     = cyc - acc_cyc[i];
          end
          if (val_w[i] && drv_ready) begin
            hs_data[i] = odat_w[i];
            hs_cnt[i]++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy[0] || m_busy[1]) && n < 200) begin
      drv_ready = 1'b1;
      tick();
      n++;
    end
    if (m_busy[0] || m_busy[1]) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // Present one op, wait for accept, return with in_valid low
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic ready);
    int base, n;
    drv_op = op; drv_a = a; drv_b = b; drv_rd = rd;
    drv_ready = ready;
    drv_valid = 1'b1;
    base = acc_cnt[0];
    n = 0;
    while (acc_cnt[0] == base && n < 10) begin
      tick();
      n++;
    end
    chk("accept", 64'(acc_cnt[0] - base), 64'd1);
    drv_valid = 1'b0;
  endtask

  task automatic wait_both_valid();
    int n;
    n = 0;
    while (val_w != 2'b11 && n < 60) begin
      tick();
      n++;
    end
    chk("valid_timeout", 64'(val_w), 64'd3);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit lit, input logic [31:0] exp,
                        input bit rnd_ready);
    int h0 [2];
    int n;
    wait_idle();
    if (lit) chk($sformatf("model_op%0d", op), 64'(ref_result(op, a, b)), 64'(exp));
    h0[0] = hs_cnt[0];
    h0[1] = hs_cnt[1];
    issue(op, a, b, rd, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    n = 0;
    while ((m_busy[0] || m_busy[1]) && n < 200) begin
      if (rnd_ready) drv_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    drv_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk(nm("handshakes", i), 64'(hs_cnt[i] - h0[i]), 64'd1);
      chk(nm("latency", i), 64'(lat[i]), (i == 0 && is_special(op, a, b)) ? 64'd0 : 64'd34);
      if (lit) chk(nm($sformatf("lit_op%0d", op), i), 64'(hs_data[i]), 64'(exp));
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] snap_d [2];
    logic [4:0]  snap_r [2];
    int base, h0;

    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed values
    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  1, 32'hFFFF_FFEB, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  1, 32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  1, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  1, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  1, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  1, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100,       32'd7,         5'd9,  1, 32'd14,        0);
    run_op(3'd7, 32'd100,       32'd7,         5'd10, 1, 32'd2,         0);
    run_op(3'd5, 32'd5,         32'd0,         5'd11, 1, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd5,         32'd0,         5'd12, 1, 32'd5,         0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'd0,         0);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0,         5'd15, 1, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0,         5'd0,  1, 32'hFFFF_FFFB, 0);

    // Backpressure: result held 10 cycles, then new op waits one edge
    wait_idle();
    issue(3'd5, 32'd100, 32'd7, 5'd17, 1'b0);
    wait_both_valid();
    snap_d[0] = odat_w[0]; snap_d[1] = odat_w[1];
    snap_r[0] = ord_w[0];  snap_r[1] = ord_w[1];
    repeat (10) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk(nm("bp_valid", i), 64'(val_w[i]), 64'd1);
        chk(nm("bp_data", i), 64'(odat_w[i]), 64'(snap_d[i]));
        chk(nm("bp_rd", i), 64'(ord_w[i]), 64'(snap_r[i]));
        chk(nm("bp_in_ready", i), 64'(rdy_w[i]), 64'd0);
      end
    end
    chk("bp_held_value", 64'(snap_d[1]), 64'd14);
    drv_op = 3'd7; drv_a = 32'd100; drv_b = 32'd7; drv_rd = 5'd18;
    drv_ready = 1'b1;
    drv_valid = 1'b1;
    base = acc_cnt[0];
    tick();
    chk("bp_no_same_edge_accept", 64'(acc_cnt[0] - base), 64'd0);
    chk("bp_ready_after_hs", 64'(rdy_w), 64'd3);
    tick();
    chk("bp_accept_next_edge", 64'(acc_cnt[0] - base), 64'd1);
    chk("bp_busy_after_accept", 64'(busy_w), 64'd3);
    chk("bp_busy_rd", 64'(brd_w[1]), 64'd18);
    drv_valid = 1'b0;
    wait_idle();
    chk("bp_second_result", 64'(hs_data[1]), 64'd2);

    // flush in CALC, reset in CALC, flush in DONE with out_ready
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 1'b1);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy_w), 64'd0);
    chk("flush_busy_rd", 64'({brd_w[1], brd_w[0]}), 64'd0);
    issue(3'd0, 32'd9, 32'd9, 5'd21, 1'b1);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy_w), 64'd0);
    chk("rst_mid_valid", 64'(val_w), 64'd0);
    issue(3'd6, 32'd50, 32'd8, 5'd22, 1'b0);
    wait_both_valid();
    h0 = hs_cnt[1];
    flush = 1'b1;
    drv_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done_no_wb", 64'(hs_cnt[1] - h0), 64'd0);
    chk("flush_done_busy", 64'(busy_w), 64'd0);
    run_op(3'd5, 32'd9, 32'd3, 5'd23, 1, 32'd3, 0);

    // Randomized ops with random writeback backpressure
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
             5'($urandom_range(0, 31)), 0, 32'd0, 1);
    end

    wait_idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
